// File: rtl/bcd_sseg_scan_driver.sv
// Four-digit multiplexed common-anode seven-segment driver for the Fibonacci BCD result.
// Latches digits on the producer's done tick, scans one digit per refresh slot and blinks on 9999.
module bcd_sseg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [3:0] i_bcd3,
    input  logic [3:0] i_bcd2,
    input  logic [3:0] i_bcd1,
    input  logic [3:0] i_bcd0,
    input  logic       i_lz_blank,
    output logic       o_valid,
    output logic [3:0] o_an,
    output logic [6:0] o_seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;
    localparam logic [6:0]       SEG_DASH = 7'h3F;
    localparam logic [3:0]       AN_OFF   = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} pattern; anything outside 0-9 shows a dash.
    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    logic [3:0]       digit_r [4];
    logic             valid_r;
    logic [CNT_W-1:0] refresh_cnt_r;
    logic [1:0]       sel_r;
    logic [FRM_W-1:0] frame_cnt_r;
    logic             phase_on_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;

    logic             wrap_s;
    logic             frame_done_s;
    logic             blink_active_s;
    logic [3:0]       lz_zero_s;
    logic             blank_s;
    logic [3:0]       cur_digit_s;
    logic [3:0]       an_next_s;
    logic [6:0]       seg_next_s;

    assign wrap_s         = (refresh_cnt_r == CNT_LAST);
    assign frame_done_s   = wrap_s && (sel_r == 2'd3);
    assign blink_active_s = ({digit_r[3], digit_r[2], digit_r[1], digit_r[0]} == 16'h9999);

    // Digit capture and valid flag; a load simply overwrites whatever is held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < 4; k++) begin
                digit_r[k] <= 4'd0;
            end
            valid_r <= 1'b0;
        end else if (i_load) begin
            digit_r[3] <= i_bcd3;
            digit_r[2] <= i_bcd2;
            digit_r[1] <= i_bcd1;
            digit_r[0] <= i_bcd0;
            valid_r    <= 1'b1;
        end
    end

    // Refresh slot timer and digit select; untouched by loads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            refresh_cnt_r <= '0;
            sel_r         <= 2'd0;
        end else if (wrap_s) begin
            refresh_cnt_r <= '0;
            sel_r         <= sel_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
        end
    end

    // Blink phase: toggles every BLINK_FRAMES complete scans while showing 9999; a load restarts it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_cnt_r <= '0;
            phase_on_r  <= 1'b1;
        end else if (i_load || !blink_active_s) begin
            frame_cnt_r <= '0;
            phase_on_r  <= 1'b1;
        end else if (frame_done_s) begin
            if (frame_cnt_r == FRM_LAST) begin
                frame_cnt_r <= '0;
                phase_on_r  <= ~phase_on_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FRM_W'(1);
            end
        end
    end

    // Next anode/segment pattern for the currently selected digit.
    always_comb begin
        cur_digit_s  = digit_r[sel_r];
        lz_zero_s[3] = (digit_r[3] == 4'd0);
        lz_zero_s[2] = lz_zero_s[3] && (digit_r[2] == 4'd0);
        lz_zero_s[1] = lz_zero_s[2] && (digit_r[1] == 4'd0);
        lz_zero_s[0] = 1'b0;
        blank_s      = i_lz_blank && lz_zero_s[sel_r];
        an_next_s    = AN_OFF;
        seg_next_s   = SEG_OFF;
        if (valid_r && phase_on_r) begin
            an_next_s = ~(4'b0001 << sel_r);
            if (blank_s) begin
                seg_next_s = SEG_OFF;
            end else begin
                seg_next_s = decode_digit(cur_digit_s);
            end
        end else begin
            an_next_s  = AN_OFF;
            seg_next_s = SEG_OFF;
        end
    end

    // Registered display outputs, one cycle behind select and digit registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_OFF;
        end else begin
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
        end
    end

    assign o_valid = valid_r;
    assign o_an    = an_r;
    assign o_seg   = seg_r;

endmodule

// File: tb/tb_bcd_sseg_scan_driver.sv
// Directed bench for bcd_sseg_scan_driver with REFRESH_DIV=4 and BLINK_FRAMES=2.
module tb_bcd_sseg_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
    logic       lz = 1'b0;
    logic       valid;
    logic [3:0] an;
    logic [6:0] seg;

    int checks = 0;
    int failures = 0;
    int n = 0;

    bcd_sseg_scan_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_load(load),
        .i_bcd3(bcd3), .i_bcd2(bcd2), .i_bcd1(bcd1), .i_bcd0(bcd0),
        .i_lz_blank(lz), .o_valid(valid), .o_an(an), .o_seg(seg)
    );

    always #5 clk = ~clk;

    // n counts edges since the reset edge (reset edge is n=0)
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
    endtask

    task automatic load_digits(input logic [3:0] d3, d2, d1, d0);
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Select expected to be shown by the outputs sampled after edge n
    function automatic logic [1:0] exp_sel();
        return 2'(((n - 1) / 4) % 4);
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid, an, seg} !== {1'b0, 4'b1111, 7'h7F}) begin
            failures++;
            $display("FAIL reset_state: got valid=%b an=%b seg=%h, expected 0 1111 7f", valid, an, seg);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({valid, an, seg} !== {1'b0, 4'b1111, 7'h7F}) begin
                failures++;
                $display("FAIL idle_dark n=%0d: got valid=%b an=%b seg=%h, expected 0 1111 7f", n, valid, an, seg);
            end
        end
    endtask

    task automatic test_scan();
        logic [6:0] tab [4];
        logic [1:0] s;
        logic [3:0] ea;
        tab = '{7'h19, 7'h30, 7'h24, 7'h79};
        do_reset();
        lz = 1'b0;
        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        checks++;
        if (valid !== 1'b1 || an !== 4'b1111) begin
            failures++;
            $display("FAIL scan_load_edge: got valid=%b an=%b, expected 1 1111", valid, an);
        end
        for (int i = 0; i < 33; i++) begin
            tick();
            s = exp_sel();
            ea = ~(4'b0001 << s);
            checks++;
            if ({an, seg} !== {ea, tab[s]}) begin
                failures++;
                $display("FAIL scan_1234 n=%0d: got an=%b seg=%h, expected an=%b seg=%h", n, an, seg, ea, tab[s]);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [1:0] s;
        logic [3:0] ea;
        logic [6:0] es;
        do_reset();
        lz = 1'b1;
        load_digits(4'd0, 4'd0, 4'd0, 4'd7);
        for (int i = 0; i < 16; i++) begin
            tick();
            s = exp_sel();
            ea = ~(4'b0001 << s);
            es = (s == 2'd0) ? 7'h78 : 7'h7F;
            checks++;
            if ({an, seg} !== {ea, es}) begin
                failures++;
                $display("FAIL lz_on_0007 n=%0d: got an=%b seg=%h, expected an=%b seg=%h", n, an, seg, ea, es);
            end
        end
        lz = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            s = exp_sel();
            ea = ~(4'b0001 << s);
            es = (s == 2'd0) ? 7'h78 : 7'h40;
            checks++;
            if ({an, seg} !== {ea, es}) begin
                failures++;
                $display("FAIL lz_off_0007 n=%0d: got an=%b seg=%h, expected an=%b seg=%h", n, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_blink();
        logic [1:0] s;
        logic [3:0] ea;
        logic [6:0] es;
        do_reset();
        lz = 1'b0;
        load_digits(4'd9, 4'd9, 4'd9, 4'd9);
        // phase turns off at edges 32, 96 and back on at edge 64; outputs lag one edge
        while (n < 110) begin
            tick();
            s = exp_sel();
            if ((((n - 1) / 32) % 2) == 0) begin
                ea = ~(4'b0001 << s);
                es = 7'h10;
            end else begin
                ea = 4'b1111;
                es = 7'h7F;
            end
            checks++;
            if ({an, seg} !== {ea, es}) begin
                failures++;
                $display("FAIL blink_9999 n=%0d: got an=%b seg=%h, expected an=%b seg=%h", n, an, seg, ea, es);
            end
        end
        load_digits(4'd0, 4'd0, 4'd0, 4'd1);
        while (n < 180) begin
            tick();
            s = exp_sel();
            ea = ~(4'b0001 << s);
            es = (s == 2'd0) ? 7'h79 : 7'h40;
            checks++;
            if ({an, seg} !== {ea, es}) begin
                failures++;
                $display("FAIL blink_stop n=%0d: got an=%b seg=%h, expected an=%b seg=%h", n, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_non_bcd();
        logic [6:0] tab [4];
        logic [1:0] s;
        logic [3:0] ea;
        tab = '{7'h12, 7'h40, 7'h3F, 7'h7F};
        do_reset();
        lz = 1'b1;
        load_digits(4'd0, 4'hF, 4'd0, 4'd5);
        for (int i = 0; i < 16; i++) begin
            tick();
            s = exp_sel();
            ea = ~(4'b0001 << s);
            checks++;
            if ({an, seg} !== {ea, tab[s]}) begin
                failures++;
                $display("FAIL non_bcd_0F05 n=%0d: got an=%b seg=%h, expected an=%b seg=%h", n, an, seg, ea, tab[s]);
            end
        end
        lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        while (n < 7) tick();
        load_digits(4'd5, 4'd6, 4'd7, 4'd8);
        checks++;
        if ({an, seg} !== {4'b1101, 7'h30}) begin
            failures++;
            $display("FAIL wrap_load_old n=%0d: got an=%b seg=%h, expected 1101 30", n, an, seg);
        end
        tick();
        checks++;
        if ({an, seg} !== {4'b1011, 7'h02}) begin
            failures++;
            $display("FAIL wrap_load_new n=%0d: got an=%b seg=%h, expected 1011 02", n, an, seg);
        end
        while (n < 13) tick();
        checks++;
        if ({an, seg} !== {4'b0111, 7'h12}) begin
            failures++;
            $display("FAIL wrap_load_d3 n=%0d: got an=%b seg=%h, expected 0111 12", n, an, seg);
        end
        while (n < 17) tick();
        checks++;
        if ({an, seg} !== {4'b1110, 7'h00}) begin
            failures++;
            $display("FAIL wrap_load_d0 n=%0d: got an=%b seg=%h, expected 1110 00", n, an, seg);
        end
        // reset mid-slot while sel=1, cnt=2
        while (n < 22) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        checks++;
        if ({valid, an, seg} !== {1'b0, 4'b1111, 7'h7F}) begin
            failures++;
            $display("FAIL midscan_reset: got valid=%b an=%b seg=%h, expected 0 1111 7f", valid, an, seg);
        end
        load_digits(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        checks++;
        if ({an, seg} !== {4'b1110, 7'h19}) begin
            failures++;
            $display("FAIL restart_sel0 n=%0d: got an=%b seg=%h, expected 1110 19", n, an, seg);
        end
        while (n < 4) tick();
        checks++;
        if ({an, seg} !== {4'b1110, 7'h19}) begin
            failures++;
            $display("FAIL restart_cnt n=%0d: got an=%b seg=%h, expected 1110 19", n, an, seg);
        end
        tick();
        checks++;
        if ({an, seg} !== {4'b1101, 7'h30}) begin
            failures++;
            $display("FAIL restart_sel1 n=%0d: got an=%b seg=%h, expected 1101 30", n, an, seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_blank();
        test_blink();
        test_non_bcd();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
